// File: rtl/addsub_la_pkg.sv
// addsub_la_pkg: operation codes and chunk geometry
// shared by the lookahead add/sub pipeline.
package addsub_la_pkg;

  typedef enum logic [1:0] {
    OP_ADD     = 2'd0,
    OP_SUB     = 2'd1,
    OP_RSUB    = 2'd2,
    OP_ABSDIFF = 2'd3
  } op_e;

  // Nominal chunk width: ceil(size / stages).
  function automatic int chunk_w(
    input int size,
    input int stages
  );
    return (size + stages - 1) / stages;
  endfunction

  // Width of chunk k; the last chunk takes the remainder.
  function automatic int stage_w(
    input int size,
    input int stages,
    input int k
  );
    if (k == stages - 1)
      return size - (stages - 1) * chunk_w(size, stages);
    return chunk_w(size, stages);
  endfunction

endpackage

// File: rtl/addsub_lookahead_pipe_cla.sv
// look_ahead_adder_n_bit: flat carry-lookahead adder,
// every carry built directly from generate/propagate terms.
module look_ahead_adder_n_bit #(
  parameter int SIZE = 4
) (
  input  logic [SIZE-1:0] i_a,
  input  logic [SIZE-1:0] i_b,
  input  logic            i_cin,
  output logic [SIZE-1:0] o_sum,
  output logic            o_cout
);

  logic [SIZE-1:0] w_g;
  logic [SIZE-1:0] w_p;
  logic [SIZE:0]   w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;
  assign w_c[0] = i_cin;

  // c[i+1] = OR_j (g[j] & p[j+1..i]) | (cin & p[0..i])
  for (genvar i = 0; i < SIZE; i++) begin : g_c
    logic [i:0] w_t;
    for (genvar j = 0; j <= i; j++) begin : g_t
      if (j == i) begin : g_own
        assign w_t[j] = w_g[j];
      end else begin : g_prop
        assign w_t[j] = w_g[j] & (&w_p[i:j+1]);
      end
    end
    assign w_c[i+1] = (|w_t) | (i_cin & (&w_p[i:0]));
  end

  assign o_sum  = w_p ^ w_c[SIZE-1:0];
  assign o_cout = w_c[SIZE];

endmodule

// File: rtl/addsub_lookahead_pipe.sv
// addsub_lookahead_pipe: chunked lookahead add/sub/rsub/absdiff pipe.
// Define ADDSUB_LA_SAT_EN for unsigned saturation of ADD/SUB/RSUB.
module addsub_lookahead_pipe
  import addsub_la_pkg::*;
#(
  parameter int SIZE   = 5,
  parameter int STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] in_a,
  input  logic [SIZE-1:0] in_b,
  input  logic [1:0]      in_op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] out_result,
  output logic            out_carry,
  output logic            out_ovf
);

  localparam int CHUNK = chunk_w(SIZE, STAGES);
  localparam int LAST  = SIZE - (STAGES - 1) * CHUNK;
  localparam int L     = STAGES - 1;

  if (SIZE < 2 || STAGES < 1 || STAGES > SIZE
      || LAST < 1) begin : g_bad_cfg
    $error("addsub_lookahead_pipe: illegal SIZE/STAGES");
  end

  logic            w_adv;

  // Stage inputs (from ports or the previous stage).
  logic            w_vld_i [STAGES];
  op_e             w_op_i  [STAGES];
  logic [SIZE-1:0] w_a_i   [STAGES];
  logic [SIZE-1:0] w_b_i   [STAGES];
  logic [SIZE-1:0] w_r1_i  [STAGES];
  logic [SIZE-1:0] w_r2_i  [STAGES];
  logic            w_c1_i  [STAGES];
  logic            w_c2_i  [STAGES];

  // Registered stage contents.
  logic            w_q_vld [STAGES];
  op_e             w_q_op  [STAGES];
  logic [SIZE-1:0] w_q_a   [STAGES];
  logic [SIZE-1:0] w_q_b   [STAGES];
  logic [SIZE-1:0] w_q_r1  [STAGES];
  logic [SIZE-1:0] w_q_r2  [STAGES];
  logic            w_q_c1  [STAGES];
  logic            w_q_c2  [STAGES];

  // Global stall: everything moves or nothing does.
  assign out_valid = w_q_vld[L];
  assign w_adv     = out_ready | ~out_valid;
  assign in_ready  = w_adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int WR = stage_w(SIZE, STAGES, k);
    localparam int W  = (WR < 1) ? 1 : WR;
    localparam int O  = k * CHUNK;

    logic [W-1:0]    w_ac;
    logic [W-1:0]    w_bc;
    logic [W-1:0]    w_nac;
    logic [W-1:0]    w_x1;
    logic [W-1:0]    w_y1;
    logic [W-1:0]    w_s1;
    logic [W-1:0]    w_s2;
    logic            w_co1;
    logic            w_co2;
    logic [SIZE-1:0] w_m1;
    logic [SIZE-1:0] w_m2;

    logic            r_vld;
    op_e             r_op;
    logic [SIZE-1:0] r_a;
    logic [SIZE-1:0] r_b;
    logic [SIZE-1:0] r_r1;
    logic [SIZE-1:0] r_r2;
    logic            r_c1;
    logic            r_c2;

    if (k == 0) begin : g_head
      assign w_vld_i[k] = in_valid;
      assign w_op_i[k]  = op_e'(in_op);
      assign w_a_i[k]   = in_a;
      assign w_b_i[k]   = in_b;
      assign w_r1_i[k]  = '0;
      assign w_r2_i[k]  = '0;
      assign w_c1_i[k]  = (op_e'(in_op) != OP_ADD);
      assign w_c2_i[k]  = 1'b1;
    end else begin : g_link
      assign w_vld_i[k] = w_q_vld[k-1];
      assign w_op_i[k]  = w_q_op[k-1];
      assign w_a_i[k]   = w_q_a[k-1];
      assign w_b_i[k]   = w_q_b[k-1];
      assign w_r1_i[k]  = w_q_r1[k-1];
      assign w_r2_i[k]  = w_q_r2[k-1];
      assign w_c1_i[k]  = w_q_c1[k-1];
      assign w_c2_i[k]  = w_q_c2[k-1];
    end

    assign w_ac  = w_a_i[k][O +: W];
    assign w_bc  = w_b_i[k][O +: W];
    assign w_nac = ~w_ac;

    // Main chain operands: A+B, A+~B or B+~A.
    always_comb begin
      w_x1 = w_ac;
      w_y1 = ~w_bc;
      unique case (1'b1)
        (w_op_i[k] == OP_ADD): w_y1 = w_bc;
        (w_op_i[k] == OP_RSUB): begin
          w_x1 = w_bc;
          w_y1 = w_nac;
        end
        default: ;
      endcase
    end

    look_ahead_adder_n_bit #(
      .SIZE (W)
    ) u_la_main (
      .i_a    (w_x1),
      .i_b    (w_y1),
      .i_cin  (w_c1_i[k]),
      .o_sum  (w_s1),
      .o_cout (w_co1)
    );

    // Second chain always forms B-A for ABSDIFF.
    look_ahead_adder_n_bit #(
      .SIZE (W)
    ) u_la_rev (
      .i_a    (w_bc),
      .i_b    (w_nac),
      .i_cin  (w_c2_i[k]),
      .o_sum  (w_s2),
      .o_cout (w_co2)
    );

    // Splice this chunk into the partial results.
    always_comb begin
      w_m1 = w_r1_i[k];
      w_m2 = w_r2_i[k];
      w_m1[O +: W] = w_s1;
      w_m2[O +: W] = w_s2;
    end

    // Stage register; holds while the pipe is stalled.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_vld <= 1'b0;
        r_op  <= OP_ADD;
        r_a   <= '0;
        r_b   <= '0;
        r_r1  <= '0;
        r_r2  <= '0;
        r_c1  <= 1'b0;
        r_c2  <= 1'b0;
      end else if (w_adv) begin
        r_vld <= w_vld_i[k];
        r_op  <= w_op_i[k];
        r_a   <= w_a_i[k];
        r_b   <= w_b_i[k];
        r_r1  <= w_m1;
        r_r2  <= w_m2;
        r_c1  <= w_co1;
        r_c2  <= w_co2;
      end
    end

    assign w_q_vld[k] = r_vld;
    assign w_q_op[k]  = r_op;
    assign w_q_a[k]   = r_a;
    assign w_q_b[k]   = r_b;
    assign w_q_r1[k]  = r_r1;
    assign w_q_r2[k]  = r_r2;
    assign w_q_c1[k]  = r_c1;
    assign w_q_c2[k]  = r_c2;
  end

  logic            w_am;
  logic            w_bm;
  logic            w_rm;
  logic [SIZE-1:0] w_res;
  logic            w_carry;
  logic            w_ovf;

  assign w_am = w_q_a[L][SIZE-1];
  assign w_bm = w_q_b[L][SIZE-1];
  assign w_rm = w_q_r1[L][SIZE-1];

  // Final select, flags and optional saturation.
  always_comb begin
    w_res   = w_q_r1[L];
    w_carry = ~w_q_c1[L];
    w_ovf   = 1'b0;
    unique case (1'b1)
      (w_q_op[L] == OP_ADD): begin
        w_carry = w_q_c1[L];
        w_ovf   = (w_am == w_bm) && (w_rm != w_am);
      end
      (w_q_op[L] == OP_SUB):
        w_ovf = (w_am != w_bm) && (w_rm != w_am);
      (w_q_op[L] == OP_RSUB):
        w_ovf = (w_am != w_bm) && (w_rm != w_bm);
      default:
        if (!w_q_c1[L]) w_res = w_q_r2[L];
    endcase
`ifdef ADDSUB_LA_SAT_EN
    if (w_q_op[L] == OP_ADD && w_q_c1[L])
      w_res = '1;
    if ((w_q_op[L] == OP_SUB || w_q_op[L] == OP_RSUB)
        && !w_q_c1[L])
      w_res = '0;
`endif
  end

  assign out_result = w_res;
  assign out_carry  = w_carry;
  assign out_ovf    = w_ovf;

endmodule
